// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: FSM states, strobe levels and widths.
package div_pkg;

  localparam int REG_W       = 32;
  localparam int DOUBLEREG_W = 2 * REG_W;
  localparam int DIV_CNT_W   = 6;

  localparam logic DIV_START           = 1'b1;
  localparam logic DIV_STOP            = 1'b0;
  localparam logic DIV_RESULT_READY    = 1'b1;
  localparam logic DIV_RESULT_NOTREADY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix on the final edge, result held until the requester drops start_i.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e          state, state_n;
  logic [2*DATA_W:0]   dvd, dvd_n;
  logic [DATA_W-1:0]   dvs, dvs_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                sign1, sign1_n, sign2, sign2_n;
  logic [2*DATA_W-1:0] result_n;
  logic                ready_n;

  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   op1_abs, op2_abs, quo, rem;
  logic                neg1, neg2;

  // Partial remainder with the next dividend bit shifted in, minus the divisor.
  assign diff    = dvd[2*DATA_W:DATA_W] - {1'b0, dvs};
  assign neg1    = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2    = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = neg1 ? -opdata1_i : opdata1_i;
  assign op2_abs = neg2 ? -opdata2_i : opdata2_i;
  assign quo     = (sign1 ^ sign2) ? -dvd[DATA_W-1:0] : dvd[DATA_W-1:0];
  assign rem     = sign1 ? -dvd[2*DATA_W:DATA_W+1] : dvd[2*DATA_W:DATA_W+1];

  always_comb begin
    state_n  = state;
    dvd_n    = dvd;
    dvs_n    = dvs;
    cnt_n    = cnt;
    sign1_n  = sign1;
    sign2_n  = sign2;
    result_n = result_o;
    ready_n  = ready_o;
    case (state)
      DIV_FREE: begin
        ready_n  = DIV_RESULT_NOTREADY;
        result_n = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = DIV_BYZERO;
          end else begin
            state_n = DIV_ON;
            cnt_n   = '0;
            dvd_n   = {{DATA_W{1'b0}}, op1_abs, 1'b0};
            dvs_n   = op2_abs;
            sign1_n = neg1;
            sign2_n = neg2;
          end
        end
      end
      DIV_BYZERO: begin
        state_n  = DIV_END;
        dvd_n    = '0;
        result_n = '0;
        ready_n  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_n = DIV_FREE;
          cnt_n   = '0;
        end else if (cnt != CNT_W'(DATA_W)) begin
          if (diff[DATA_W]) dvd_n = {dvd[2*DATA_W-1:0], 1'b0};
          else              dvd_n = {diff[DATA_W-1:0], dvd[DATA_W-1:0], 1'b1};
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = DIV_END;
          cnt_n    = '0;
          result_n = {rem, quo};
          ready_n  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_n  = DIV_FREE;
          ready_n  = DIV_RESULT_NOTREADY;
          result_n = '0;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      dvd      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOTREADY;
    end else begin
      state    <= state_n;
      dvd      <= dvd_n;
      dvs      <= dvs_n;
      cnt      <= cnt_n;
      sign1    <= sign1_n;
      sign2    <= sign2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: the driver queues expected {rem, quo} and the ready edge,
// a monitor pops on each rising ready_o and compares value and latency.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic rdy_q = 1'b0;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready_o && !rdy_q) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready_o=1 result %h expected no result", result_o);
        end else begin
          e = q.pop_front();
          chk("result", result_o, e.res);
          chk("latency_edge", 64'(edge_cnt), 64'(e.due));
        end
      end
      rdy_q = ready_o;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, scramble operands after the sampling edge, then exercise
  // the END hold and the release handshake.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
    int n;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    q.push_back('{exp, edge_cnt + 1 + lat});
    step();
    opdata1_i = 32'hDEADBEEF;
    opdata2_i = 32'h0;
    n = 0;
    while (!ready_o && n < 60) begin
      step();
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_o=0 after %0d cycles expected ready_o=1", n);
    end
    step();
    chk("end_hold_ready", 64'(ready_o), 64'd1);
    chk("end_hold_result", result_o, exp);
    start_i = 1'b0;
    step();
    chk("release_ready", 64'(ready_o), 64'd0);
    chk("release_result", result_o, 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) step();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    step();

    run_div(1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
    run_div(1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33);
    run_div(1'b0, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, 33);
    run_div(1'b0, 32'h1234,     32'd0,        64'h0,                 1);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33);

    // Annul at iteration 10: nothing queued, so any ready is flagged by the monitor.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    step();
    repeat (10) step();
    annul_i = 1'b1; start_i = 1'b0;
    step();
    annul_i = 1'b0;
    repeat (40) step();
    chk("annul_ready", 64'(ready_o), 64'd0);
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    // Reset at iteration 20.
    signed_div_i = 1'b0; opdata1_i = 32'd5000; opdata2_i = 32'd9; start_i = 1'b1;
    step();
    repeat (20) step();
    rst = 1'b1; start_i = 1'b0;
    step();
    chk("midreset_ready", 64'(ready_o), 64'd0);
    chk("midreset_result", result_o, 64'd0);
    rst = 1'b0;
    repeat (40) step();
    chk("midreset_quiet", 64'(ready_o), 64'd0);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);

    repeat (2) step();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle iterative divider that serves the execute stage for DIV/DIVU.
- EX issues operands plus a start strobe and holds them. div runs a 32-step restoring shift-subtract, then returns a 64-bit {remainder, quotient} with a ready flag.
- EX stalls the pipeline while the divide is busy. It writes the result to HI/LO once it sees ready.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits, result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (`RSTENABLE = 1'b1`), sampled on rising edge of clk.
- signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request; EX holds it and the operands high until it consumes ready_o.
- annul_i  input  1  cancel an in-flight divide (pipeline flush/exception).
- result_o  output  2*DATA_W  [63:32] remainder (to HI), [31:0] quotient (to LO).
- ready_o  output  1  result valid.

Behaviour:
- Reset: state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend register=0. rst overrides all other inputs, including mid-divide; no partial result survives.
- Internal state: 65-bit dividend register dvd, DATA_W-bit divisor register dvs, counter cnt, latched operand signs.
- State FREE:
  - start_i=1 and annul_i=0 with opdata2_i==0: go to BYZERO.
  - start_i=1 and annul_i=0 with opdata2_i!=0: go to ON, cnt=0.
    - dvd={0, |op1|, 1'b0}; dvs=|op2|.
    - Absolute values are taken only when signed_div_i=1; otherwise operands are used raw.
    - Latch sign1=op1[31] and sign2=op2[31] (both forced 0 when unsigned).
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- State BYZERO: next edge go to END with dvd=0, so the result is 0/0 and no trap is raised.
- State ON, annul_i=1: go to FREE, cnt=0; ready_o stays 0.
- State ON, annul_i=0 and cnt<DATA_W:
  - diff = dvd[64:32] - {1'b0, dvs}.
  - diff negative: dvd <= {dvd[63:0], 1'b0}.
  - diff non-negative: dvd <= {diff[31:0], dvd[31:0], 1'b1}.
  - cnt <= cnt+1.
- State ON, cnt==DATA_W (sign-fix edge):
  - quotient = dvd[31:0], negated if sign1^sign2.
  - remainder = dvd[64:33], negated if sign1.
  - Go to END, cnt=0; result_o={remainder, quotient}; ready_o=1 on this same edge.
- State END:
  - ready_o=1 and result_o are held while start_i=1.
  - When start_i=0: go to FREE, ready_o=0, result_o=0.
  - annul_i is ignored in END.
- Latency, edge E0 = edge that samples start_i in FREE:
  - Nonzero divisor: E1..E32 iterate; E33 performs the sign fix; ready_o is high in the cycle after E33.
  - Zero divisor: ready_o is high in the cycle after E1.
- Arithmetic rules:
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - Signed 0x80000000 / 0xFFFFFFFF wraps: quotient=0x80000000, remainder=0.
  - |0x80000000| is treated as unsigned 2^31.
- Operands are sampled only at E0; later changes on opdata*_i have no effect.
- start_i dropping during ON does not abort; only annul_i aborts.

Decomposition:
- Shared macro header (alongside the existing ALU-op macros):
  - state encodings DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2 bits);
  - DIVSTART/DIVSTOP and DIVRESULTREADY/DIVRESULTNOTREADY;
  - DOUBLEREGBUS width macro.
- EX gains the matching div request/stall logic separately.
- Single flat module; no sub-module is warranted.

Test Plan:
- Unsigned, op1=7, op2=2, start held → ready_o rises in the cycle after E33; result_o=0x00000001_00000003. Drop start → FREE, ready_o=0 next edge.
- Signed, op1=0xFFFFFFF9 (-7), op2=2 → result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). Signed 7 / -2 → 0x00000001_FFFFFFFD.
- Divide by zero, op1=0x1234, op2=0 → ready_o rises in the cycle after E1; result_o=0.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Check annul and reset:
  - Pulse annul_i at iteration 10 → FREE, ready_o never asserts. A new 100/7 unsigned request then gives 0x00000002_0000000E.
  - Assert rst at iteration 20 → all outputs 0 at next edge, state FREE.
